// File: rtl/cape_p9_41_42_gpio.sv
// APB-programmable GPIO controller for cape pins P9_41/P9_42.
// Bit 0 of every register maps to pin 41 and bit 1 maps to pin 42.
module cape_p9_41_42_gpio #(
    parameter int DEB_W = 16
) (
    input  logic          PCLK,
    input  logic          PRESETN,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [7:0]    PADDR,
    input  logic [31:0]   PWDATA,
    output logic [31:0]   PRDATA,
    output logic          PREADY,
    output logic          PSLVERR,
    output logic [42:41]  GPIO_OUT,
    output logic [42:41]  GPIO_OE,
    input  logic [42:41]  GPIO_IN,
    output logic          IRQ
);

    localparam logic [5:0] IDX_OUT    = 6'h00;
    localparam logic [5:0] IDX_OE     = 6'h01;
    localparam logic [5:0] IDX_IN     = 6'h02;
    localparam logic [5:0] IDX_IRQ_EN = 6'h03;
    localparam logic [5:0] IDX_STATUS = 6'h04;
    localparam logic [5:0] IDX_DEB    = 6'h05;

    logic [1:0]       out_reg;
    logic [1:0]       oe_reg;
    logic [3:0]       irq_en;
    logic [1:0]       status;
    logic [DEB_W-1:0] deb_n;

    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       filt;
    logic [1:0]       filt_d;
    logic [DEB_W-1:0] cnt      [2];
    logic [DEB_W-1:0] cnt_next [2];
    logic [DEB_W:0]   cnt_inc  [2];
    logic [1:0]       filt_next;

    logic             wr_en;
    logic [5:0]       reg_idx;
    logic [1:0]       w1c_mask;
    logic [1:0]       edge_set;
    logic             unused_bits;

    assign wr_en   = PSEL & PENABLE & PWRITE;
    assign reg_idx = PADDR[7:2];

    assign unused_bits = ^{PWDATA[31:DEB_W], PADDR[1:0]};

    // Debounce: the counter runs only while sync disagrees with the filtered
    // state; N of 0 or 1 both let filtered follow sync after one cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_inc[i]   = {1'b0, cnt[i]} + {{DEB_W{1'b0}}, 1'b1};
            cnt_next[i]  = '0;
            filt_next[i] = filt[i];
            if (sync2[i] != filt[i]) begin
                if (cnt_inc[i] >= {1'b0, deb_n}) begin
                    filt_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt_inc[i][DEB_W-1:0];
                end
            end
        end
    end

    assign edge_set = ((filt & ~filt_d) & irq_en[1:0]) |
                      ((~filt & filt_d) & irq_en[3:2]);

    assign w1c_mask = (wr_en && reg_idx == IDX_STATUS) ? PWDATA[1:0] : 2'b00;

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            out_reg <= '0;
            oe_reg  <= '0;
            irq_en  <= '0;
            status  <= '0;
            deb_n   <= '0;
            sync1   <= '0;
            sync2   <= '0;
            filt    <= '0;
            filt_d  <= '0;
            cnt[0]  <= '0;
            cnt[1]  <= '0;
        end else begin
            sync1  <= GPIO_IN;
            sync2  <= sync1;
            filt   <= filt_next;
            filt_d <= filt;
            cnt[0] <= cnt_next[0];
            cnt[1] <= cnt_next[1];
            // A new edge in the same cycle as a W1C keeps the bit set.
            status <= (status & ~w1c_mask) | edge_set;
            if (wr_en) begin
                case (reg_idx)
                    IDX_OUT:    out_reg <= PWDATA[1:0];
                    IDX_OE:     oe_reg  <= PWDATA[1:0];
                    IDX_IRQ_EN: irq_en  <= PWDATA[3:0];
                    IDX_DEB:    deb_n   <= PWDATA[DEB_W-1:0];
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (reg_idx)
                IDX_OUT:    PRDATA = {30'd0, out_reg};
                IDX_OE:     PRDATA = {30'd0, oe_reg};
                IDX_IN:     PRDATA = {30'd0, filt};
                IDX_IRQ_EN: PRDATA = {28'd0, irq_en};
                IDX_STATUS: PRDATA = {30'd0, status};
                IDX_DEB:    PRDATA = 32'(deb_n);
                default:    PRDATA = '0;
            endcase
        end
    end

    assign GPIO_OUT = out_reg;
    assign GPIO_OE  = oe_reg;
    assign IRQ      = |status;
    assign PREADY   = 1'b1;
    assign PSLVERR  = 1'b0;

endmodule

// File: tb/tb_cape_p9_41_42_gpio.sv
// Directed self-checking bench for cape_p9_41_42_gpio: APB access, debounce
// boundaries, edge interrupts, W1C/set collision and mid-debounce reset.
`timescale 1ns/1ps
module tb_cape_p9_41_42_gpio;

    logic         PCLK;
    logic         PRESETN;
    logic         PSEL;
    logic         PENABLE;
    logic         PWRITE;
    logic [7:0]   PADDR;
    logic [31:0]  PWDATA;
    logic [31:0]  PRDATA;
    logic         PREADY;
    logic         PSLVERR;
    logic [42:41] GPIO_OUT;
    logic [42:41] GPIO_OE;
    logic [42:41] GPIO_IN;
    logic         IRQ;

    int errors = 0;
    int checks = 0;

    cape_p9_41_42_gpio #(.DEB_W(16)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .GPIO_OUT(GPIO_OUT),
        .GPIO_OE(GPIO_OE), .GPIO_IN(GPIO_IN), .IRQ(IRQ)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] pins);
        GPIO_IN = pins;
    endtask

    // Setup phase on the next edge, access phase (write) on the one after.
    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        tick(1);
        PENABLE = 1'b1;
        tick(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        #1;
        data = PRDATA;
        PSEL = 1'b0;
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        apb_read(addr, rd);
        checkOutput(tag, rd, exp);
    endtask

    task automatic check_pins(input string tag, input logic [1:0] out_exp,
                              input logic [1:0] oe_exp, input logic irq_exp);
        checkOutput({tag, "_gpio_out"}, {30'd0, GPIO_OUT}, {30'd0, out_exp});
        checkOutput({tag, "_gpio_oe"},  {30'd0, GPIO_OE},  {30'd0, oe_exp});
        checkOutput({tag, "_irq"},      {31'd0, IRQ},      {31'd0, irq_exp});
    endtask

    initial begin
        PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        applyStimulus(2'b00);
        tick(2);
        PRESETN = 1'b1;
        tick(1);

        // Reset state
        check_pins("rst", 2'b00, 2'b00, 1'b0);
        checkOutput("rst_pready",  {31'd0, PREADY},  32'h1);
        checkOutput("rst_pslverr", {31'd0, PSLVERR}, 32'h0);
        check_reg("rst_out",    8'h00, 32'h0);
        check_reg("rst_oe",     8'h04, 32'h0);
        check_reg("rst_in",     8'h08, 32'h0);
        check_reg("rst_irq_en", 8'h0C, 32'h0);
        check_reg("rst_status", 8'h10, 32'h0);
        check_reg("rst_deb",    8'h14, 32'h0);
        check_reg("rst_unmap",  8'h18, 32'h0);

        // Output path updates at the write edge
        apb_write(8'h04, 32'h3);
        check_pins("oe_wr", 2'b00, 2'b11, 1'b0);
        apb_write(8'h00, 32'h2);
        check_pins("out_wr", 2'b10, 2'b11, 1'b0);
        check_reg("out_rd", 8'h00, 32'h2);
        apb_write(8'h00, 32'hFFFF_FFFD);
        check_reg("out_upper_ignored", 8'h00, 32'h1);
        apb_write(8'h19, 32'hFFFF_FFFF);
        check_reg("unmap_wr", 8'h18, 32'h0);
        check_reg("unmap_no_side", 8'h00, 32'h1);
        apb_write(8'h14, 32'hABCD_1234);
        check_reg("deb_rd", 8'h14, 32'h0000_1234);

        // DEB = 0, rise enable on pin 41: IN after k+2, IRQ after k+3
        apb_write(8'h14, 32'h0);
        apb_write(8'h0C, 32'h1);
        applyStimulus(2'b01);
        tick(2);
        check_reg("n0_in_k1", 8'h08, 32'h0);
        tick(1);
        check_reg("n0_in_k2", 8'h08, 32'h1);
        checkOutput("n0_irq_k2", {31'd0, IRQ}, 32'h0);
        tick(1);
        check_reg("n0_status_k3", 8'h10, 32'h1);
        checkOutput("n0_irq_k3", {31'd0, IRQ}, 32'h1);
        apb_write(8'h10, 32'h1);
        checkOutput("w1c_irq", {31'd0, IRQ}, 32'h0);
        check_reg("w1c_status", 8'h10, 32'h0);

        // DEB = 5, rise enable on pin 42: 4-cycle pulse is filtered out
        apb_write(8'h14, 32'h5);
        apb_write(8'h0C, 32'h2);
        applyStimulus(2'b11);
        tick(4);
        applyStimulus(2'b01);
        tick(8);
        check_reg("glitch4_in", 8'h08, 32'h1);
        check_reg("glitch4_status", 8'h10, 32'h0);
        checkOutput("glitch4_irq", {31'd0, IRQ}, 32'h0);

        // 5-cycle pulse: sync rises at k+1, IN[1] at k+6, status at k+7
        applyStimulus(2'b11);
        tick(5);
        applyStimulus(2'b01);
        tick(1);
        check_reg("pulse5_in_k5", 8'h08, 32'h1);
        tick(1);
        check_reg("pulse5_in_k6", 8'h08, 32'h3);
        checkOutput("pulse5_irq_k6", {31'd0, IRQ}, 32'h0);
        tick(1);
        check_reg("pulse5_status_k7", 8'h10, 32'h2);
        checkOutput("pulse5_irq_k7", {31'd0, IRQ}, 32'h1);
        tick(8);
        check_reg("pulse5_in_fell", 8'h08, 32'h1);
        check_reg("pulse5_fall_disabled", 8'h10, 32'h2);
        apb_write(8'h10, 32'h2);
        checkOutput("pulse5_clr_irq", {31'd0, IRQ}, 32'h0);

        // Fall enable on pin 42 with a W1C landing on the setting edge
        apb_write(8'h14, 32'h0);
        apb_write(8'h0C, 32'h8);
        applyStimulus(2'b11);
        tick(4);
        check_reg("fall_rise_ignored", 8'h10, 32'h0);
        applyStimulus(2'b01);
        tick(2);
        apb_write(8'h10, 32'h2);
        check_reg("set_beats_w1c", 8'h10, 32'h2);
        checkOutput("set_beats_w1c_irq", {31'd0, IRQ}, 32'h1);
        apb_write(8'h10, 32'h2);
        check_reg("fall_clr", 8'h10, 32'h0);

        // Reset while outputs driven, status pending and a count in flight
        apb_write(8'h00, 32'h3);
        apb_write(8'h0C, 32'h4);
        applyStimulus(2'b00);
        tick(4);
        check_reg("pre_rst_status", 8'h10, 32'h1);
        check_pins("pre_rst", 2'b11, 2'b11, 1'b1);
        apb_write(8'h14, 32'd10);
        applyStimulus(2'b10);
        tick(4);
        check_reg("mid_deb_in", 8'h08, 32'h0);
        PRESETN = 1'b0;
        tick(1);
        check_pins("in_rst", 2'b00, 2'b00, 1'b0);
        checkOutput("in_rst_pready",  {31'd0, PREADY},  32'h1);
        checkOutput("in_rst_pslverr", {31'd0, PSLVERR}, 32'h0);
        check_reg("in_rst_out",    8'h00, 32'h0);
        check_reg("in_rst_in",     8'h08, 32'h0);
        check_reg("in_rst_irq_en", 8'h0C, 32'h0);
        check_reg("in_rst_status", 8'h10, 32'h0);
        check_reg("in_rst_deb",    8'h14, 32'h0);
        PRESETN = 1'b1;
        tick(4);
        check_reg("post_rst_in", 8'h08, 32'h2);
        check_reg("post_rst_status", 8'h10, 32'h0);
        checkOutput("post_rst_irq", {31'd0, IRQ}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cape_p9_41_42_gpio.md
# cape_p9_41_42_gpio

APB-programmable GPIO controller for cape header pins P9_41 and P9_42, sitting directly upstream of the P9_41/P9_42 bidirectional pad block. It drives the per-pin output value and output-enable, and synchronizes, debounces and edge-detects the pad input. Edges can raise an interrupt to the MSS fabric interrupt input. Register bit 0 maps to pin 41 and bit 1 to pin 42 throughout.

## Interface
- DEB_W, 16, width of the debounce count register and per-pin counters.
- PCLK  in  1  APB/fabric clock; every flop is on its rising edge.
- PRESETN  in  1  synchronous, active-low reset, sampled on PCLK.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  8  byte address; bits [1:0] ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1 (zero wait states).
- PSLVERR  out  1  tied 0.
- GPIO_OUT  out  [42:41]  pad output value.
- GPIO_OE  out  [42:41]  pad output enable; 1 = drive.
- GPIO_IN  in  [42:41]  raw pad input; asynchronous to PCLK.
- IRQ  out  1  level interrupt; OR of IRQ_STATUS bits.

## Operation
- Register map (32-bit words; unused bits read 0, ignore writes; unmapped addresses read 0, writes have no effect):
  - 0x00 OUT, RW [1:0], drives GPIO_OUT[41]/[42].
  - 0x04 OE, RW [1:0], drives GPIO_OE.
  - 0x08 IN, RO [1:0], debounced input state.
  - 0x0C IRQ_EN, RW: [1:0] rising-edge enable, [3:2] falling-edge enable.
  - 0x10 IRQ_STATUS, W1C [1:0]: latched edge events.
  - 0x14 DEB, RW [DEB_W-1:0], debounce count N.
- Write occurs at the PCLK edge where PSEL & PENABLE & PWRITE = 1.
- PRDATA is combinational from PADDR when PSEL & ~PWRITE; 0 otherwise.
- Input path per pin: 2-flop synchronizer -> debounce filter -> filtered state (IN) -> edge detector.
- Debounce: per-pin counter cnt. If sync == filtered, cnt <= 0. If sync != filtered: when cnt+1 >= N, filtered <= sync and cnt <= 0; otherwise cnt <= cnt+1. N = 0 and N = 1 are identical: filtered follows sync with 1 cycle of delay. A glitch shorter than N cycles never changes filtered.
- Edge detect: a filtered 0->1 transition with rise-enable = 1 sets the status bit; a 1->0 transition with fall-enable = 1 sets it. Edges while disabled are not remembered.
- Set and W1C of the same status bit in the same cycle: set wins.
- A DEB write mid-count takes effect on the next comparison; cnt is not cleared.
- IRQ = |IRQ_STATUS[1:0] (combinational from status flops).

## Timing
- Reset (PRESETN = 0 at a PCLK edge): OUT, OE, IRQ_EN, IRQ_STATUS, DEB, synchronizer flops, filtered state and counters all 0. Therefore GPIO_OUT = 0, GPIO_OE = 0, IRQ = 0, PRDATA = 0. PREADY stays 1 and PSLVERR stays 0.
- Reset mid-debounce discards the count. A pin held high through reset gives a filtered 0->1 after release, but no status is set because IRQ_EN = 0.
- GPIO_OUT/GPIO_OE update at the same edge as the APB write completes.
- GPIO_IN change sampled at edge k: sync valid at k+1, filtered at k+2 (N ≤ 1) or k+1+N (N ≥ 2), status and IRQ at the following edge.
- An IRQ_STATUS W1C write at edge k clears IRQ after edge k, unless a new edge is set in that same cycle.

## Test plan
- Reset, then read all registers -> every read returns 0x0; GPIO_OE = 2'b00, IRQ = 0.
- Write OE = 0x3, then OUT = 0x2 -> GPIO_OE = 2'b11 and GPIO_OUT = {1,0} at the write edge; reading OUT returns 0x2.
- DEB = 0, IRQ_EN = 0x1, raise GPIO_IN[41] before edge k -> IN[0] = 1 after edge k+2, IRQ_STATUS = 0x1 and IRQ = 1 after k+3. Writing 0x1 to 0x10 then clears IRQ.
- DEB = 5: a 4-cycle high pulse on GPIO_IN[42] -> IN stays 0 and no IRQ. A 5-cycle pulse -> IN[1] rises exactly 5 edges after sync changes.
- IRQ_EN = 0x8, drop GPIO_IN[42] from 1 to 0 -> IRQ_STATUS = 0x2. Also issue a W1C of 0x2 in the same cycle the edge sets the bit -> the status bit stays 1.
- Assert PRESETN low mid-debounce with OUT = 0x3 and status pending -> all outputs and registers return to 0 on the next edge.
